// File: rtl/sub_serial.sv
// Bit-serial two's-complement subtractor: a - b, one bit per clock, LSB first.
// Operands load on a start request; result and final borrow report with a level done handshake.
module sub_serial #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSub,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic              borrow_q, borrow_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              diff_bit;
    logic              borrow_nxt;

    // Full-subtractor cell on the current LSBs.
    always_comb begin
        diff_bit   = a_q[0] ^ b_q[0] ^ borrow_q;
        borrow_nxt = (~a_q[0] & b_q[0]) | (~a_q[0] & borrow_q) | (b_q[0] & borrow_q);
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        out_d    = out_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (en) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    out_d    = '0;
                    state_d  = StSub;
                end
            end
            StSub: begin
                borrow_d = borrow_nxt;
                out_d    = {diff_bit, out_q[WIDTH-1:1]};
                a_d      = {1'b0, a_q[WIDTH-1:1]};
                b_d      = {1'b0, b_q[WIDTH-1:1]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // Four-phase: wait for en to drop before accepting another start.
                if (!en) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            out_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            out_q    <= out_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        out        = out_q;
        borrow_out = borrow_q;
        busy       = (state_q == StSub);
        done       = (state_q == StDone);
    end

endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial: directed cases plus random sweeps at WIDTH=8 and WIDTH=4.
module tb_sub_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       en8, en4;
    logic [7:0] a8, b8, out8;
    logic [3:0] a4, b4, out4;
    logic       bo8, busy8, done8;
    logic       bo4, busy4, done4;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    sub_serial #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .rst        (rst),
        .en         (en8),
        .a          (a8),
        .b          (b8),
        .out        (out8),
        .borrow_out (bo8),
        .busy       (busy8),
        .done       (done8)
    );

    sub_serial #(.WIDTH(4)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .en         (en4),
        .a          (a4),
        .b          (b4),
        .out        (out4),
        .borrow_out (bo4),
        .busy       (busy4),
        .done       (done4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One operation on the 8-bit instance; returns cycles from start edge to done and busy count.
    task automatic op8(input logic [7:0] ai, input logic [7:0] bi, input bit disturb,
                       input bit hold, output int lat, output int busy_cnt);
        en8 = 1'b0;
        @(posedge clk); #1;
        a8  = ai;
        b8  = bi;
        en8 = 1'b1;
        @(posedge clk); #1;
        lat      = 0;
        busy_cnt = 0;
        if (!hold) en8 = 1'b0;
        while (!done8 && lat < 40) begin
            if (busy8) busy_cnt++;
            if (disturb) begin
                a8  = 8'hFF;
                b8  = 8'hFF;
                en8 = ~en8;
            end
            @(posedge clk); #1;
            lat++;
        end
        if (disturb) en8 = 1'b0;
    endtask

    task automatic op4(input logic [3:0] ai, input logic [3:0] bi, output int lat);
        en4 = 1'b0;
        @(posedge clk); #1;
        a4  = ai;
        b4  = bi;
        en4 = 1'b1;
        @(posedge clk); #1;
        en4 = 1'b0;
        lat = 0;
        while (!done4 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat, bc, bad, nerr;
        logic [7:0] ra, rb, expd;
        logic [3:0] qa, qb, expq;

        rst = 1'b0;
        en8 = 1'b0; en4 = 1'b0;
        a8 = '0; b8 = '0; a4 = '0; b4 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", out8, 8'h00);
        check("rst_borrow", bo8, 1'b0);
        check("rst_busy", busy8, 1'b0);
        check("rst_done", done8, 1'b0);
        rst = 1'b1;

        op8(8'h05, 8'h03, 1'b0, 1'b0, lat, bc);
        check("5m3_out", out8, 8'h02);
        check("5m3_borrow", bo8, 1'b0);
        check("5m3_latency", lat, 8);
        check("5m3_busy_cycles", bc, 8);
        check("5m3_busy_low", busy8, 1'b0);

        op8(8'h03, 8'h05, 1'b0, 1'b0, lat, bc);
        check("3m5_out", out8, 8'hFE);
        check("3m5_borrow", bo8, 1'b1);
        op8(8'h00, 8'h01, 1'b0, 1'b0, lat, bc);
        check("0m1_out", out8, 8'hFF);
        check("0m1_borrow", bo8, 1'b1);
        op8(8'h80, 8'h80, 1'b0, 1'b0, lat, bc);
        check("80m80_out", out8, 8'h00);
        check("80m80_borrow", bo8, 1'b0);

        op8(8'hA5, 8'h5A, 1'b1, 1'b0, lat, bc);
        check("disturb_out", out8, 8'h4B);
        check("disturb_borrow", bo8, 1'b0);
        check("disturb_latency", lat, 8);

        // en held high: single operation, done and out stable through cycle 20.
        op8(8'h37, 8'h12, 1'b0, 1'b1, lat, bc);
        check("hold_latency", lat, 8);
        bad = 0;
        for (int c = 9; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done8 !== 1'b1 || busy8 !== 1'b0 || out8 !== 8'h25) bad++;
        end
        check("hold_stable", bad, 0);
        en8 = 1'b0;
        @(posedge clk); #1;
        check("hold_release_done", done8, 1'b0);
        check("hold_release_busy", busy8, 1'b0);
        op8(8'h01, 8'h02, 1'b0, 1'b0, lat, bc);
        check("1m2_out", out8, 8'hFF);
        check("1m2_borrow", bo8, 1'b1);

        // Reset mid-SUB must clear outputs without waiting for a clock edge.
        en8 = 1'b0;
        @(posedge clk); #1;
        a8 = 8'hC3; b8 = 8'h11; en8 = 1'b1;
        @(posedge clk); #1;
        en8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_busy", busy8, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("arst_out", out8, 8'h00);
        check("arst_borrow", bo8, 1'b0);
        check("arst_busy", busy8, 1'b0);
        check("arst_done", done8, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        op8(8'h09, 8'h04, 1'b0, 1'b0, lat, bc);
        check("9m4_out", out8, 8'h05);
        check("9m4_borrow", bo8, 1'b0);
        check("9m4_latency", lat, 8);

        nerr = 0;
        for (int i = 0; i < 500; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            expd = 8'((int'(ra) - int'(rb) + 256) % 256);
            op8(ra, rb, 1'b0, 1'b0, lat, bc);
            check("rand8_out", out8, expd);
            check("rand8_borrow", bo8, (ra < rb));
            if (lat != 8) nerr++;
        end
        check("rand8_latency_errors", nerr, 0);

        nerr = 0;
        for (int i = 0; i < 500; i++) begin
            qa = 4'($urandom);
            qb = 4'($urandom);
            expq = 4'((int'(qa) - int'(qb) + 16) % 16);
            op4(qa, qb, lat);
            check("rand4_out", out4, expq);
            check("rand4_borrow", bo4, (qa < qb));
            if (lat != 4) nerr++;
        end
        check("rand4_latency_errors", nerr, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/sub_serial.md
# sub_serial

Bit-serial two's-complement subtractor that computes `a - b` one bit per clock, LSB first, using a single full-subtractor cell and a borrow flop. It is the inverse-operation companion to the serial adder in the same arithmetic datapath and uses the same load/shift/accumulate scheme, so the two can be swapped behind a common controller. Operands are captured in parallel on a start request. The difference is assembled in a right-shifting result register and reported with a final borrow and a level `done` handshake.

## Interface

Parameters:
- `WIDTH`, default 8: operand and result width in bits, minimum 2.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset. Asserting low forces reset immediately; deassertion is synchronous to `clk` upstream.
- `en`  in  1  start request and acknowledge level.
- `a`  in  WIDTH  minuend, sampled only at the start edge.
- `b`  in  WIDTH  subtrahend, sampled only at the start edge.
- `out`  out  WIDTH  difference `a - b` modulo 2^WIDTH, registered.
- `borrow_out`  out  1  final borrow (1 when `a < b` unsigned), registered.
- `busy`  out  1  high while in SUB.
- `done`  out  1  high while in DONE.

## Operation

- Internal state: FSM `{IDLE, SUB, DONE}`, plus these registers:
  - `a_reg`, `b_reg`: WIDTH bits each.
  - `borrow`: 1 bit.
  - `count`: clog2(WIDTH) bits.
- IDLE:
  - With `en`=1: load `a_reg<=a`, `b_reg<=b`, `borrow<=0`, `count<=0`, `out<=0`, then go to SUB.
  - With `en`=0: hold all registers.
- SUB, every cycle:
  - `d = a_reg[0] ^ b_reg[0] ^ borrow`
  - `borrow <= (~a_reg[0] & b_reg[0]) | (~a_reg[0] & borrow) | (b_reg[0] & borrow)`
  - `out <= {d, out[WIDTH-1:1]}`
  - `a_reg`, `b_reg` shift right by 1 with zero fill.
  - `count <= count+1`.
  - When `count == WIDTH-1`, go to DONE on this edge; otherwise stay in SUB.
- DONE:
  - `out` and `borrow` hold; `borrow_out` mirrors `borrow`.
  - While `en`=1, stay in DONE.
  - When `en`=0, go to IDLE. This is a four-phase handshake: no automatic restart while `en` is held high.
- `en`, `a` and `b` are ignored in SUB. Operand changes after the start edge have no effect.
- `busy` and `done` are pure decodes of the state register and are glitch-free relative to `clk`.
- Arithmetic: unsigned modulo-2^WIDTH subtraction. The result equals the two's-complement difference. No overflow flag.

## Timing

- Reset values:
  - `out`=0, `borrow_out`=0, `busy`=0, `done`=0.
  - State is IDLE; `a_reg`, `b_reg` and `count` are 0.
- Start edge E0: `en`=1 sampled in IDLE. `busy` is high after E0.
- Bit k of `out` is computed at edge E(k+1). The final edge is E(WIDTH), after which:
  - `done`=1 and `busy`=0;
  - `out` and `borrow_out` are valid and stable.
- Total latency is WIDTH cycles from start edge to `done`. The minimum period between starts is WIDTH+2 cycles: WIDTH for SUB, 1 in DONE with `en` low, and 1 in IDLE.
- If `en` is continuously high, the block stays in DONE indefinitely. After `en` falls it reaches IDLE one edge later, and a new start requires `en`=1 in IDLE.
- During SUB, `out` holds partial, shifting data. Consumers must qualify `out` with `done`.
- Reset mid-operation (in any state) aborts immediately. All outputs return to reset values asynchronously and the FSM is in IDLE on the first edge after release.
- If `en`=1 on the first edge after reset release, that edge is a valid start edge.

## Test plan

- Reset then `a`=5, `b`=3, `en` pulse → `done` after 8 cycles, `out`=0x02, `borrow_out`=0; `busy` high exactly 8 cycles.
- `a`=3, `b`=5 → `out`=0xFE, `borrow_out`=1. `a`=0x00, `b`=0x01 → `out`=0xFF, `borrow_out`=1. `a`=0x80, `b`=0x80 → `out`=0x00, `borrow_out`=0.
- `a`=0xA5, `b`=0x5A, then change `a`/`b` to 0xFF and toggle `en` during SUB → `out`=0x4B, `borrow_out`=0, `done` after exactly 8 cycles.
- Hold `en`=1 for 20 cycles → single operation. `done` stays high from cycle 8 to 20 and `out` is stable. `en` low → IDLE next edge; a new start with `a`=1, `b`=2 gives `out`=0xFF, `borrow_out`=1.
- Assert `rst` low at cycle 4 of SUB → all outputs 0 asynchronously. After release, `a`=9, `b`=4 gives `out`=0x05 with correct latency.
- Random sweep of 1000 operand pairs (including WIDTH=4 build) checked against the `a - b` reference model and the `a < b` borrow.
